bs_fetch: RTL and testbench



---
 rtl/bs_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_bs_fetch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_fetch.sv
// ---------------------------------------------------------------------------
// bs_fetch
//
// Bitstream fetch stage in front of the h264i decoder. Reads the coded
// stream from external memory as 64-bit words over a req/ack port, buffers
// them in a small FIFO and hands them to the decoder MSB-first as 16-bit
// halfwords, one halfword per ao_next pulse.
//
// Parameters
//   ADDR_W     width of the word address and of the word count
//   DEPTH      FIFO depth in 64-bit words (power of 2, >= 2)
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle launch pulse, ignored while busy
//   base_addr  first word address, sampled on start
//   word_count number of words to deliver, sampled on start
//   mem_req    read request, held until acknowledged
//   mem_addr   word address of the pending request
//   mem_ack    one-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  read data, bit 63 is the first stream bit
//   ai_data    current halfword to the decoder
//   ai_we      ai_data is valid (FIFO not empty)
//   ao_next    decoder consumes the current halfword this cycle
//   busy       high from start until the last halfword is consumed
//   done       one-cycle pulse after the last halfword is consumed
// ---------------------------------------------------------------------------
module bs_fetch #(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    output logic [15:0]       ai_data,
    output logic              ai_we,
    input  logic              ao_next,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    // S_WAIT is the "REQ, but no free slot" substate: mem_req is held low
    // until the decoder pops a word.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t              state;
    logic [63:0]         fifo [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [FILL_W-1:0]   fill;
    logic [FILL_W-1:0]   fill_next;
    logic [1:0]          hw_sel;
    logic [ADDR_W-1:0]   fetch_left;
    logic [ADDR_W-1:0]   addr;
    logic                push;
    logic                consume;
    logic                pop;

    // An acknowledge only counts while we are actually requesting, so stray
    // or late acks (e.g. after a reset) are dropped.
    assign push    = (state == S_REQ) && mem_req && mem_ack;
    assign consume = ao_next && ai_we;
    assign pop     = consume && (hw_sel == 2'd3);

    assign ai_we    = (fill != '0);
    assign mem_addr = addr;

    // Occupancy after this edge; the FSM uses it to decide whether another
    // request can be issued without overrunning the FIFO.
    always_comb begin
        fill_next = fill;
        if (push && !pop) begin
            fill_next = fill + FILL_W'(1);
        end else if (!push && pop) begin
            fill_next = fill - FILL_W'(1);
        end
    end

    // Halfword selection from the head word, MSB first. Forced to zero when
    // the FIFO is empty so the output is clean out of reset.
    always_comb begin
        ai_data = 16'h0000;
        if (ai_we) begin
            case (hw_sel)
                2'd0: ai_data = fifo[rd_ptr][63:48];
                2'd1: ai_data = fifo[rd_ptr][47:32];
                2'd2: ai_data = fifo[rd_ptr][31:16];
                2'd3: ai_data = fifo[rd_ptr][15:0];
            endcase
        end
    end

    // FIFO storage needs no reset: the contents are only visible while fill
    // is non-zero, and fill itself is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= mem_rdata;
        end
    end

    // Pointers, occupancy and halfword index. hw_sel wraps 3 -> 0 naturally
    // on the consume that pops the head word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            hw_sel <= 2'd0;
        end else begin
            fill <= fill_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (consume) begin
                hw_sel <= hw_sel + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Fetch FSM. Entering S_REQ from S_IDLE spends one cycle with mem_req
    // low before raising it; afterwards mem_req is decided on the ack edge
    // so back-to-back requests keep it high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            addr       <= '0;
            fetch_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr       <= base_addr;
                            fetch_left <= word_count;
                            busy       <= 1'b1;
                            state      <= S_REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        addr       <= addr + ADDR_W'(1);
                        fetch_left <= fetch_left - ADDR_W'(1);
                        if (fetch_left == ADDR_W'(1)) begin
                            mem_req <= 1'b0;
                            state   <= S_DRAIN;
                        end else if (fill_next < FILL_W'(DEPTH)) begin
                            mem_req <= 1'b1;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (fill_next < FILL_W'(DEPTH)) begin
                        mem_req <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (fill_next == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_fetch.sv
// ---------------------------------------------------------------------------
// tb_bs_fetch
//
// Self-checking bench for bs_fetch. A memory responder acks requests and
// pushes the expected halfwords of every accepted word into a queue; a
// decoder model pops and compares them whenever it consumes a halfword.
// ---------------------------------------------------------------------------
module tb_bs_fetch;

    localparam int ADDR_W = 20;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [63:0]       mem_rdata;
    logic [15:0]       ai_data;
    logic              ai_we;
    logic              ao_next;
    logic              busy;
    logic              done;

    int n_cmp;
    int n_fail;

    logic [15:0]       exp_q [$];
    logic [ADDR_W-1:0] addr_log [$];
    logic [ADDR_W-1:0] exp_addr;

    // mem_mode: 0 = silent, 1 = ack while requested (ack_pct %), 2 = ack every cycle
    int mem_mode;
    int ack_pct;
    // nxt_mode: 0 = never consume, 1 = always, 2 = random 30 %
    int nxt_mode;

    int acks;
    int hw_consumed;
    int done_total;
    int req_cycles;
    int cyc;
    int last_cons_cyc;
    int word_pop_cyc;

    bs_fetch #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ai_data    (ai_data),
        .ai_we      (ai_we),
        .ao_next    (ao_next),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents: a fixed word at 0x10, an address-derived pattern elsewhere.
    function automatic logic [63:0] memWord(input logic [ADDR_W-1:0] a);
        if (a == 20'h00010) begin
            return 64'h0123_4567_89AB_CDEF;
        end
        return {16'hA5A5 ^ a[15:0], 16'h3C00 | {12'h000, a[19:16]}, ~a[15:0], a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Memory responder and scoreboard producer.
    initial begin
        logic [63:0] w;
        logic        ack;
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (mem_mode == 1) begin
                ack = mem_req && ($urandom_range(99) < 32'(ack_pct));
            end else if (mem_mode == 2) begin
                ack = 1'b1;
            end
            mem_ack   = ack;
            mem_rdata = memWord(mem_addr);
            if (mem_req) begin
                req_cycles++;
            end
            if (ack && mem_req) begin
                checkOutput("mem_addr", 64'(mem_addr), 64'(exp_addr));
                addr_log.push_back(mem_addr);
                w = memWord(exp_addr);
                exp_q.push_back(w[63:48]);
                exp_q.push_back(w[47:32]);
                exp_q.push_back(w[31:16]);
                exp_q.push_back(w[15:0]);
                exp_addr = exp_addr + ADDR_W'(1);
                acks++;
            end
        end
    end

    // Decoder model and scoreboard consumer.
    initial begin
        ao_next = 1'b0;
        forever begin
            @(negedge clk);
            case (nxt_mode)
                1:       ao_next = 1'b1;
                2:       ao_next = ($urandom_range(99) < 30);
                default: ao_next = 1'b0;
            endcase
            if (ao_next && ai_we) begin
                checkOutput("sb_avail", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    checkOutput("ai_data", 64'(ai_data), 64'(exp_q.pop_front()));
                end
                hw_consumed++;
                last_cons_cyc = cyc;
                if ((hw_consumed % 4) == 0) begin
                    word_pop_cyc = cyc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_total++;
            end
        end
    end

    task automatic pulseStart(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count);
        exp_addr = base;
        pulseStart(base, count);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_mem_req"},  64'(mem_req),  64'(0));
        checkOutput({pfx, "_mem_addr"}, 64'(mem_addr), 64'(0));
        checkOutput({pfx, "_ai_we"},    64'(ai_we),    64'(0));
        checkOutput({pfx, "_ai_data"},  64'(ai_data),  64'(0));
        checkOutput({pfx, "_busy"},     64'(busy),     64'(0));
        checkOutput({pfx, "_done"},     64'(done),     64'(0));
    endtask

    task automatic doReset();
        mem_mode = 0;
        nxt_mode = 0;
        start    = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        checkResetOutputs("rst");
        exp_q.delete();
        addr_log.delete();
        acks          = 0;
        hw_consumed   = 0;
        done_total    = 0;
        req_cycles    = 0;
        last_cons_cyc = -10;
        word_pop_cyc  = -10;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic waitDone(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 64'(got), 64'(1));
        if (got) begin
            checkOutput("done_timing", 64'(cyc), 64'(last_cons_cyc + 1));
            checkOutput("busy_at_done", 64'(busy), 64'(0));
            @(negedge clk);
            checkOutput("done_width", 64'(done), 64'(0));
        end
    endtask

    initial begin
        logic [63:0] w;
        logic        got;
        n_cmp      = 0;
        n_fail     = 0;
        reset_n    = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        exp_addr   = '0;
        mem_mode   = 0;
        nxt_mode   = 0;
        ack_pct    = 100;

        // Basic order: single word, decoder always ready.
        doReset();
        mem_mode = 1;
        ack_pct  = 100;
        nxt_mode = 1;
        applyStimulus(20'h00010, 20'd1);
        checkOutput("req_lat_n", 64'(mem_req), 64'(0));
        checkOutput("busy_start", 64'(busy), 64'(1));
        @(negedge clk);
        #1;
        checkOutput("req_lat_n1", 64'(mem_req), 64'(1));
        checkOutput("mem_addr_basic", 64'(mem_addr), 64'h10);
        @(negedge clk);
        #1;
        checkOutput("ack_we", 64'(ai_we), 64'(1));
        checkOutput("ack_data", 64'(ai_data), 64'h0123);
        waitDone(50);
        @(negedge clk);
        #1;
        checkOutput("we_after_done", 64'(ai_we), 64'(0));
        checkOutput("done_count", 64'(done_total), 64'(1));
        checkOutput("acks_basic", 64'(acks), 64'(1));
        checkOutput("hw_basic", 64'(hw_consumed), 64'(4));
        checkOutput("sb_left_basic", 64'(exp_q.size()), 64'(0));

        // Backpressure: memory acks every cycle, decoder stalled.
        doReset();
        mem_mode = 2;
        nxt_mode = 0;
        applyStimulus(20'h00100, 20'd8);
        repeat (12) @(negedge clk);
        #1;
        w = memWord(20'h00100);
        checkOutput("bp_acks", 64'(acks), 64'(DEPTH));
        checkOutput("bp_req_low", 64'(mem_req), 64'(0));
        checkOutput("bp_we", 64'(ai_we), 64'(1));
        checkOutput("bp_data", 64'(ai_data), 64'(w[63:48]));
        nxt_mode = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("bp_req_seen", 64'(got), 64'(1));
        checkOutput("bp_req_after_pop", 64'(cyc), 64'(word_pop_cyc + 1));
        waitDone(300);
        #1;
        checkOutput("bp_acks_total", 64'(acks), 64'(8));
        checkOutput("bp_hw", 64'(hw_consumed), 64'(32));
        checkOutput("sb_left_bp", 64'(exp_q.size()), 64'(0));

        // Slow decoder with a slow memory creating ai_we gaps.
        doReset();
        mem_mode = 1;
        ack_pct  = 25;
        nxt_mode = 2;
        applyStimulus(20'h00200, 20'd6);
        waitDone(3000);
        #1;
        checkOutput("slow_acks", 64'(acks), 64'(6));
        checkOutput("slow_hw", 64'(hw_consumed), 64'(24));
        checkOutput("sb_left_slow", 64'(exp_q.size()), 64'(0));

        // Zero-length start, then a start ignored while busy.
        doReset();
        mem_mode = 1;
        ack_pct  = 100;
        nxt_mode = 1;
        applyStimulus(20'h00300, 20'd0);
        checkOutput("zero_done", 64'(done), 64'(1));
        checkOutput("zero_busy", 64'(busy), 64'(0));
        @(negedge clk);
        #1;
        checkOutput("zero_done_width", 64'(done), 64'(0));
        repeat (8) @(negedge clk);
        #1;
        checkOutput("zero_no_req", 64'(req_cycles), 64'(0));
        checkOutput("zero_done_count", 64'(done_total), 64'(1));
        applyStimulus(20'h00400, 20'd3);
        repeat (2) @(negedge clk);
        pulseStart(20'h00500, 20'd5);
        waitDone(200);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("busy_start_acks", 64'(acks), 64'(3));
        checkOutput("busy_start_hw", 64'(hw_consumed), 64'(12));
        checkOutput("sb_left_busy", 64'(exp_q.size()), 64'(0));
        checkOutput("busy_start_idle", 64'(busy), 64'(0));

        // Address wrap at the top of the address space.
        doReset();
        mem_mode = 1;
        ack_pct  = 100;
        nxt_mode = 1;
        applyStimulus(20'hFFFFF, 20'd2);
        waitDone(100);
        #1;
        checkOutput("wrap_n", 64'(addr_log.size()), 64'(2));
        if (addr_log.size() >= 2) begin
            checkOutput("wrap_a0", 64'(addr_log[0]), 64'hFFFFF);
            checkOutput("wrap_a1", 64'(addr_log[1]), 64'h00000);
        end

        // Reset in the middle of a transfer, followed by late acks.
        doReset();
        mem_mode = 2;
        nxt_mode = 0;
        applyStimulus(20'h00600, 20'd4);
        repeat (3) @(negedge clk);
        #2;
        checkOutput("mrst_busy_before", 64'(busy), 64'(1));
        checkOutput("mrst_we_before", 64'(ai_we), 64'(1));
        mem_mode = 0;
        reset_n  = 1'b0;
        #1;
        checkResetOutputs("mrst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        mem_mode = 2;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("late_ack_we", 64'(ai_we), 64'(0));
        checkOutput("late_ack_req", 64'(mem_req), 64'(0));
        checkOutput("late_ack_busy", 64'(busy), 64'(0));
        mem_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
